// File: rtl/cla144_sched.sv
// cla144_sched: shares one 144-bit carry-lookahead adder between two requesters, with
// locked multi-beat chains. Define CLA144_SCHED_OVF_EN to add the rsp_ovf output.
module cla144_sched #(
  parameter int WIDTH = 144
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req0_last,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  input  logic             req1_last,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id,
`ifdef CLA144_SCHED_OVF_EN
  output logic             rsp_last,
  output logic             rsp_ovf
`else
  output logic             rsp_last
`endif
);

  localparam int NGRP = WIDTH / 4;
  localparam int NSUP = NGRP / 4;

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t           state;
  logic             rr;
  logic             grant0;
  logic             grant1;
  logic             s1_load;
  logic             s2_load;
  logic             acc0;
  logic             acc1;
  logic             acc;
  logic             acc_id;
  logic             acc_last;
  logic             acc_cin;
  logic [WIDTH-1:0] acc_a;
  logic [WIDTH-1:0] acc_b;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;
  logic             s1_id;
  logic             s1_last;
  logic             s1_chain;

  logic             carry_reg;
  logic             cin_used;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  // rr = 1 means requester 1 has priority when both are valid in IDLE.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (state)
      LOCK0: grant0 = 1'b1;
      LOCK1: grant1 = 1'b1;
      default: begin
        if (req0_valid && req1_valid) begin
          grant0 = !rr;
          grant1 = rr;
        end else begin
          grant0 = req0_valid;
          grant1 = req1_valid;
        end
      end
    endcase
  end

  assign s2_load    = !rsp_valid || rsp_ready;
  assign s1_load    = !s1_valid || s2_load;
  assign req0_ready = grant0 && s1_load && !rst;
  assign req1_ready = grant1 && s1_load && !rst;

  assign acc0     = req0_valid && req0_ready;
  assign acc1     = req1_valid && req1_ready;
  assign acc      = acc0 || acc1;
  assign acc_id   = acc1;
  assign acc_a    = acc1 ? req1_a : req0_a;
  assign acc_b    = acc1 ? req1_b : req0_b;
  assign acc_cin  = acc1 ? req1_cin : req0_cin;
  assign acc_last = acc1 ? req1_last : req0_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr    <= 1'b0;
    end else if (acc) begin
      if (acc_last) begin
        state <= IDLE;
        rr    <= !acc_id;
      end else if (state == IDLE) begin
        state <= acc_id ? LOCK1 : LOCK0;
      end
    end
  end

  // Any beat accepted while locked continues a chain and takes the registered carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
      s1_id    <= 1'b0;
      s1_last  <= 1'b0;
      s1_chain <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= acc;
      if (acc) begin
        s1_a     <= acc_a;
        s1_b     <= acc_b;
        s1_cin   <= acc_cin;
        s1_id    <= acc_id;
        s1_last  <= acc_last;
        s1_chain <= (state != IDLE);
      end
    end
  end

  assign cin_used = s1_chain ? carry_reg : s1_cin;

  // Three-level lookahead: 4-bit groups, 16-bit supergroups, then the full word.
  always_comb begin : cla_core
    logic [WIDTH-1:0] bg;
    logic [WIDTH-1:0] bp;
    logic [WIDTH-1:0] bc;
    logic [NGRP-1:0]  gg;
    logic [NGRP-1:0]  gp;
    logic [NGRP-1:0]  gc;
    logic [NSUP-1:0]  sg;
    logic [NSUP-1:0]  sp;
    logic [NSUP-1:0]  sc;
    logic             g_out;
    logic             p_out;

    bg = s1_a & s1_b;
    bp = s1_a ^ s1_b;
    for (int k = 0; k < NGRP; k++) begin
      gg[k] = bg[4*k+3] | (bp[4*k+3] & bg[4*k+2]) | (bp[4*k+3] & bp[4*k+2] & bg[4*k+1])
            | (bp[4*k+3] & bp[4*k+2] & bp[4*k+1] & bg[4*k]);
      gp[k] = &bp[4*k +: 4];
    end
    for (int j = 0; j < NSUP; j++) begin
      sg[j] = gg[4*j+3] | (gp[4*j+3] & gg[4*j+2]) | (gp[4*j+3] & gp[4*j+2] & gg[4*j+1])
            | (gp[4*j+3] & gp[4*j+2] & gp[4*j+1] & gg[4*j]);
      sp[j] = &gp[4*j +: 4];
    end
    g_out = 1'b0;
    p_out = 1'b1;
    for (int j = 0; j < NSUP; j++) begin
      g_out = sg[j] | (sp[j] & g_out);
      p_out = p_out & sp[j];
    end
    sc[0] = cin_used;
    for (int j = 1; j < NSUP; j++) begin
      sc[j] = sg[j-1] | (sp[j-1] & sc[j-1]);
    end
    for (int j = 0; j < NSUP; j++) begin
      gc[4*j] = sc[j];
      for (int i = 1; i < 4; i++) begin
        gc[4*j+i] = gg[4*j+i-1] | (gp[4*j+i-1] & gc[4*j+i-1]);
      end
    end
    for (int k = 0; k < NGRP; k++) begin
      bc[4*k] = gc[k];
      for (int i = 1; i < 4; i++) begin
        bc[4*k+i] = bg[4*k+i-1] | (bp[4*k+i-1] & bc[4*k+i-1]);
      end
    end
    add_sum  = bp ^ bc;
    add_cout = g_out | (p_out & cin_used);
  end

  // Carry is only captured when a real beat moves on, so bubbles leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_last  <= 1'b0;
      carry_reg <= 1'b0;
`ifdef CLA144_SCHED_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else if (s2_load) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_sum   <= add_sum;
        rsp_cout  <= add_cout;
        rsp_id    <= s1_id;
        rsp_last  <= s1_last;
        carry_reg <= add_cout;
`ifdef CLA144_SCHED_OVF_EN
        rsp_ovf   <= s1_a[WIDTH-1] ^ s1_b[WIDTH-1] ^ add_sum[WIDTH-1] ^ add_cout;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cla144_sched.sv
// tb_cla144_sched: table vectors, directed chain/backpressure/reset sequences and a
// randomized run of cla144_sched against a scoreboard model (honours CLA144_SCHED_OVF_EN).
module tb_cla144_sched;
  localparam int WIDTH = 144;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req0_cin, req0_last;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready, req1_cin, req1_last;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             rsp_valid, rsp_ready, rsp_cout, rsp_id, rsp_last;
  logic [WIDTH-1:0] rsp_sum;
`ifdef CLA144_SCHED_OVF_EN
  logic             rsp_ovf;
  logic             pop_ovf;
`endif

  always #5 clk = ~clk;

  cla144_sched #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_cin(req0_cin), .req0_last(req0_last),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_cin(req1_cin), .req1_last(req1_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_id(rsp_id),
    .rsp_last(rsp_last)
`ifdef CLA144_SCHED_OVF_EN
    , .rsp_ovf(rsp_ovf)
`endif
  );

  typedef struct {
    logic             rs, rr;
    logic             v0, c0, l0;
    logic [WIDTH-1:0] a0, b0;
    logic             v1, c1, l1;
    logic [WIDTH-1:0] a1, b1;
  } stim_t;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout, id, last, ovf;
  } rsp_t;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout, ovf;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Scoreboard model: expected results in order, pipeline occupancy, lock and priority.
  rsp_t             exp_q[$];
  int               inflight = 0;
  int               lock_id = -1;
  int               prio = 0;
  logic             chain_carry = 1'b0;
  int               pops = 0;
  int               accepts = 0;
  logic             hold_valid = 1'b0;
  logic [WIDTH-1:0] hold_sum;
  logic             hold_cout, hold_id, hold_last;
  logic             seen_r0, seen_r1, seen_valid;
  logic [WIDTH-1:0] pop_sum;
  logic             pop_cout, pop_id, pop_last;

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  task automatic checkInt(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic recordAccept(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic cin, input logic last);
    rsp_t           r;
    logic [WIDTH:0] full;
    logic           c;
    c      = (lock_id == id) ? chain_carry : cin;
    full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.id   = (id == 1);
    r.last = last;
    r.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
    chain_carry = r.cout;
    exp_q.push_back(r);
    inflight++;
    accepts++;
    if (last) begin
      lock_id = -1;
      prio    = 1 - id;
    end else begin
      lock_id = id;
    end
  endtask

  task automatic monitorCycle();
    logic can, e0, e1;
    rsp_t r;
    seen_r0    = req0_ready;
    seen_r1    = req1_ready;
    seen_valid = rsp_valid;
    if (rst) begin
      checkBit("ready0_in_reset", req0_ready, 1'b0);
      checkBit("ready1_in_reset", req1_ready, 1'b0);
      exp_q.delete();
      inflight   = 0;
      lock_id    = -1;
      prio       = 0;
      hold_valid = 1'b0;
      return;
    end
    can = (inflight < 2) || rsp_ready;
    e0  = 1'b0;
    e1  = 1'b0;
    if (lock_id == 0) e0 = can;
    else if (lock_id == 1) e1 = can;
    else if (req0_valid && req1_valid) begin
      if (prio == 0) e0 = can;
      else e1 = can;
    end else begin
      e0 = req0_valid & can;
      e1 = req1_valid & can;
    end
    checkBit("req0_ready", req0_ready, e0);
    checkBit("req1_ready", req1_ready, e1);
    if (hold_valid) begin
      checkBit("hold_valid", rsp_valid, 1'b1);
      checkOutput("hold_sum", rsp_sum, hold_sum);
      checkBit("hold_cout", rsp_cout, hold_cout);
      checkBit("hold_id", rsp_id, hold_id);
      checkBit("hold_last", rsp_last, hold_last);
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: got sum %0h expected no response", rsp_sum);
      end else begin
        r = exp_q.pop_front();
        checkOutput("rsp_sum", rsp_sum, r.sum);
        checkBit("rsp_cout", rsp_cout, r.cout);
        checkBit("rsp_id", rsp_id, r.id);
        checkBit("rsp_last", rsp_last, r.last);
`ifdef CLA144_SCHED_OVF_EN
        checkBit("rsp_ovf", rsp_ovf, r.ovf);
        pop_ovf = rsp_ovf;
`endif
      end
      pop_sum  = rsp_sum;
      pop_cout = rsp_cout;
      pop_id   = rsp_id;
      pop_last = rsp_last;
      pops++;
      inflight--;
    end
    hold_valid = rsp_valid && !rsp_ready;
    hold_sum   = rsp_sum;
    hold_cout  = rsp_cout;
    hold_id    = rsp_id;
    hold_last  = rsp_last;
    if (req0_valid && req0_ready) recordAccept(0, req0_a, req0_b, req0_cin, req0_last);
    if (req1_valid && req1_ready) recordAccept(1, req1_a, req1_b, req1_cin, req1_last);
  endtask

  // Drives one cycle's inputs at the falling edge and samples just after.
  task automatic applyStimulus(input stim_t s);
    rst        = s.rs;
    rsp_ready  = s.rr;
    req0_valid = s.v0; req0_a = s.a0; req0_b = s.b0; req0_cin = s.c0; req0_last = s.l0;
    req1_valid = s.v1; req1_a = s.a1; req1_b = s.b1; req1_cin = s.c1; req1_last = s.l1;
    #1;
    monitorCycle();
    @(negedge clk);
  endtask

  function automatic stim_t idleStim(input logic rr);
    stim_t s;
    s.rs = 1'b0; s.rr = rr;
    s.v0 = 1'b0; s.c0 = 1'b0; s.l0 = 1'b1; s.a0 = '0; s.b0 = '0;
    s.v1 = 1'b0; s.c1 = 1'b0; s.l1 = 1'b1; s.a1 = '0; s.b1 = '0;
    return s;
  endfunction

  function automatic stim_t beatStim(input int id, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b, input logic cin,
                                     input logic last, input logic rr);
    stim_t s;
    s = idleStim(rr);
    if (id == 0) begin
      s.v0 = 1'b1; s.a0 = a; s.b0 = b; s.c0 = cin; s.l0 = last;
    end else begin
      s.v1 = 1'b1; s.a1 = a; s.b1 = b; s.c1 = cin; s.l1 = last;
    end
    return s;
  endfunction

  function automatic logic [WIDTH-1:0] randWide();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return '0;
      2:       return {{(WIDTH-32){1'b0}}, r[31:0]};
      default: return r[WIDTH-1:0];
    endcase
  endfunction

  initial begin
    vec_t             vecs[8];
    stim_t            s;
    logic [WIDTH-1:0] all1, msb, maxpos;
    int               p0, a0;
    logic             prev_g1;

    all1   = '1;
    msb    = '0;
    msb[WIDTH-1] = 1'b1;
    maxpos = msb - 1'b1;
    vecs[0] = '{0, all1,   {{(WIDTH-1){1'b0}}, 1'b1}, 1'b0, '0,        1'b1, 1'b0};
    vecs[1] = '{0, 144'd3, 144'd4,                    1'b0, 144'd7,    1'b0, 1'b0};
    vecs[2] = '{1, '0,     '0,                        1'b1, 144'd1,    1'b0, 1'b0};
    vecs[3] = '{1, all1,   all1,                      1'b1, all1,      1'b1, 1'b0};
    vecs[4] = '{0, maxpos, 144'd1,                    1'b0, msb,       1'b0, 1'b1};
    vecs[5] = '{0, maxpos, all1,                      1'b0, msb - 144'd2, 1'b1, 1'b0};
    vecs[6] = '{1, msb,    msb,                       1'b0, '0,        1'b1, 1'b1};
    vecs[7] = '{1, 144'd5, 144'd7,                    1'b1, 144'd13,   1'b0, 1'b0};

    s = idleStim(1'b1);
    s.rs = 1'b1;
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0; req0_last = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0; req1_last = 1'b0;
    @(negedge clk);
    applyStimulus(s);
    applyStimulus(s);
    checkBit("reset_rsp_valid", rsp_valid, 1'b0);
    checkOutput("reset_rsp_sum", rsp_sum, '0);
    checkBit("reset_rsp_cout", rsp_cout, 1'b0);
    checkBit("reset_rsp_id", rsp_id, 1'b0);
    checkBit("reset_rsp_last", rsp_last, 1'b0);
`ifdef CLA144_SCHED_OVF_EN
    checkBit("reset_rsp_ovf", rsp_ovf, 1'b0);
`endif

    // Single-beat vectors: result must appear exactly two samples after acceptance.
    for (int i = 0; i < 8; i++) begin
      p0 = pops;
      applyStimulus(beatStim(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1, 1'b1));
      applyStimulus(idleStim(1'b1));
      checkInt("vec_latency_early", pops - p0, 0);
      applyStimulus(idleStim(1'b1));
      checkInt("vec_latency", pops - p0, 1);
      checkOutput("vec_sum", pop_sum, vecs[i].sum);
      checkBit("vec_cout", pop_cout, vecs[i].cout);
      checkBit("vec_id", pop_id, (vecs[i].id == 1));
`ifdef CLA144_SCHED_OVF_EN
      checkBit("vec_ovf", pop_ovf, vecs[i].ovf);
`endif
    end

    // Two-beat chain on requester 1 while requester 0 waits.
    applyStimulus(beatStim(1, all1, '0, 1'b1, 1'b0, 1'b1));
    s = beatStim(1, 144'd5, 144'd7, 1'b0, 1'b1, 1'b1);
    s.v0 = 1'b1; s.a0 = 144'd9; s.b0 = 144'd9; s.l0 = 1'b1;
    applyStimulus(s);
    checkBit("chain_req0_held", seen_r0, 1'b0);
    checkBit("chain_beat1_taken", seen_r1, 1'b1);
    applyStimulus(beatStim(0, 144'd9, 144'd9, 1'b0, 1'b1, 1'b1));
    checkOutput("chain_sum0", pop_sum, '0);
    checkBit("chain_cout0", pop_cout, 1'b1);
    applyStimulus(idleStim(1'b1));
    checkOutput("chain_sum1", pop_sum, 144'd13);
    checkBit("chain_cout1", pop_cout, 1'b0);
    checkBit("chain_last1", pop_last, 1'b1);
    applyStimulus(idleStim(1'b1));
    checkOutput("after_chain_sum", pop_sum, 144'd18);

    // Both requesters always valid: grants must alternate.
    for (int i = 0; i < 8; i++) begin
      s = beatStim(0, randWide(), randWide(), 1'b0, 1'b1, 1'b1);
      s.v1 = 1'b1; s.a1 = randWide(); s.b1 = randWide(); s.l1 = 1'b1;
      applyStimulus(s);
      checkBit("alt_onehot", seen_r0 ^ seen_r1, 1'b1);
      if (i > 0) checkBit("alt_flip", seen_r1, !prev_g1);
      prev_g1 = seen_r1;
    end
    for (int i = 0; i < 3; i++) applyStimulus(idleStim(1'b1));

    // Backpressure: consumer stalls for five cycles with a stream offered.
    a0 = accepts;
    for (int i = 0; i < 5; i++)
      applyStimulus(beatStim(0, 144'(100 + i), 144'(i), 1'b0, 1'b1, 1'b0));
    checkInt("bp_accepts", accepts - a0, 2);
    p0 = pops;
    for (int i = 0; i < 4; i++) applyStimulus(idleStim(1'b1));
    checkInt("bp_release_pops", pops - p0, 2);

    // Reset in the middle of a chain drops the lock and the in-flight beat.
    applyStimulus(beatStim(0, 144'd1, 144'd1, 1'b0, 1'b0, 1'b1));
    s = idleStim(1'b1);
    s.rs = 1'b1;
    applyStimulus(s);
    applyStimulus(beatStim(1, 144'd1, 144'd2, 1'b0, 1'b1, 1'b1));
    checkBit("rst_chain_rsp_valid", seen_valid, 1'b0);
    checkBit("rst_chain_idle", seen_r1, 1'b1);
    applyStimulus(beatStim(0, 144'd3, 144'd4, 1'b0, 1'b1, 1'b1));
    applyStimulus(idleStim(1'b1));
    applyStimulus(idleStim(1'b1));
    checkOutput("rst_fresh_sum", pop_sum, 144'd7);
    checkBit("rst_fresh_cout", pop_cout, 1'b0);
    checkBit("rst_fresh_id", pop_id, 1'b0);

    // Randomized traffic against the scoreboard.
    for (int cyc = 0; cyc < 600; cyc++) begin
      s.rs = 1'b0;
      s.rr = ($urandom_range(0, 3) != 0);
      s.v0 = ($urandom_range(0, 2) != 0); s.a0 = randWide(); s.b0 = randWide();
      s.c0 = ($urandom_range(0, 1) == 1); s.l0 = ($urandom_range(0, 2) != 0);
      s.v1 = ($urandom_range(0, 2) != 0); s.a1 = randWide(); s.b1 = randWide();
      s.c1 = ($urandom_range(0, 1) == 1); s.l1 = ($urandom_range(0, 2) != 0);
      applyStimulus(s);
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) applyStimulus(idleStim(1'b1));
    checkInt("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla144_sched.md
# cla144_sched

Two-requester scheduler that time-shares one 144-bit carry-lookahead adder (CLA144) between independent clients. It supports multi-word (chained) additions by locking the grant and forwarding carry-out between beats. Operands, carry-in selection and results are registered around the combinational adder. Sits between the butterfly datapath's wide-add users (e.g. modular-reduction and accumulate stages) and a single CLA144 instance.

## Interface
- WIDTH, 144, operand/sum width; fixed to match CLA144
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req0_valid / req1_valid  in  1  operand beat offered by requester 0 / 1
- req0_ready / req1_ready  out  1  beat accepted on a cycle with valid & ready
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  addends
- req0_cin / req1_cin  in  1  carry-in; used only on the first beat of an operation
- req0_last / req1_last  in  1  1 = final beat of the operation; 0 = more beats follow
- rsp_valid  out  1  result register holds a valid beat
- rsp_ready  in  1  consumer accepts the result
- rsp_sum  out  WIDTH  sum of the beat
- rsp_cout  out  1  carry-out of the beat, g_out | (p_out & carry-in used)
- rsp_id  out  1  requester that issued the beat
- rsp_last  out  1  copy of the beat's last flag
- rsp_ovf  out  1  signed overflow of the beat; only with CLA144_SCHED_OVF_EN

## Operation
- Arbiter FSM states: IDLE, LOCK0, LOCK1.
  - IDLE: grant by round-robin; rr pointer starts at requester 0. Priority goes to the requester not granted most recently. When only one requester is valid, it is granted.
  - IDLE -> LOCKn: accepted beat from n has last=0.
  - LOCKn: only requester n may be granted; the other's ready stays 0.
  - LOCKn -> IDLE: accepted beat from n has last=1.
  - The rr pointer updates on every accepted beat whose last=1.
- Stage 1 (operand register): holds a, b, id, last, and chain flag. Chain flag = 1 for every beat except the first of an operation.
- Adder carry-in: carry register if chain flag = 1, else the captured cin.
- Stage 2 (result register): captures sum, cout, id, last, and ovf; drives rsp_*.
- Carry register: loaded with the adder carry-out whenever stage 1 advances into stage 2.
- Advance rule: stage 2 loads when it is empty or rsp_ready = 1. Stage 1 loads when it is empty or stage 2 loads.
- reqN_ready = grant_to_N & stage-1-can-load. ready is not combinationally dependent on reqN_valid of the other requester except through the arbiter.
- Arithmetic: {cout, sum} = a + b + carry-in, modulo 2^WIDTH with carry-out kept; no saturation.

## Timing
- Reset values: all ready = 0 during rst; rsp_valid = 0; rsp_sum = 0; rsp_cout/id/last/ovf = 0.
  - Reset leaves FSM = IDLE, rr = 0, both stages empty, carry register = 0.
- Latency: beat accepted at edge E appears on rsp_* after edge E+1; rsp_valid is high in the cycle following E+1.
- Throughput: one beat per cycle, including back-to-back chained beats. The carry from beat k is registered at the same edge at which beat k+1 enters stage 1.
- Backpressure: with rsp_ready = 0 and both stages full, all ready = 0. rsp_* hold stable until accepted.
- Simultaneous valid in IDLE: exactly one ready asserts; the other requester waits at least one cycle.
- A locked requester that drops valid mid-chain keeps the lock indefinitely; bubbles do not corrupt the carry register.
- Reset mid-chain drops the lock, clears both stages, and discards in-flight beats. A requester must restart its operation.

## Configuration
- CLA144_SCHED_OVF_EN defined:
  - rsp_ovf is present.
  - rsp_ovf = carry into bit WIDTH-1 XOR carry-out, computed as a[WIDTH-1]^b[WIDTH-1]^sum[WIDTH-1]^cout.
  - rsp_ovf is registered with sum.
- Not defined: the rsp_ovf port and its logic are absent; all other behaviour is unchanged.

## Test plan
- Single add, req0: a=2^144-1, b=1, cin=0, last=1 -> 2 cycles later rsp_sum=0, rsp_cout=1, rsp_id=0, rsp_last=1.
- Two-beat chain, req1: beat0 a=2^144-1, b=0, cin=1, last=0; beat1 a=5, b=7, last=1; both beats back-to-back -> sums 0 then 13, couts 1 then 0. req0 held off (ready=0) throughout the chain.
- Both valid every cycle, all last=1, rsp_ready=1 -> grants alternate 0,1,0,1 and rsp_id alternates; no beat is lost.
- rsp_ready low for 5 cycles with a stream offered -> at most 2 beats accepted, rsp_* stable. On release, results arrive in order with correct values.
- rst asserted mid-chain (after beat0, last=0) -> next cycle rsp_valid=0, FSM IDLE. A fresh req0 single add of 3+4 returns 7 with cout=0.
- OVF_EN: a=2^143-1, b=1 -> rsp_ovf=1. Same a with b=2^144-1 -> rsp_ovf=0.
